// File: rtl/noc_sa_pkg.sv
// Shared switch-allocator types: default widths, per-VC request bundle and the local SA FSM states.
package noc_sa_pkg;

  localparam int QOS_W        = 4;
  localparam int OUT_PORT_NUM = 6;
  localparam int OUT_PORT_W   = 3;

  typedef struct packed {
    logic                  vld;
    logic [QOS_W-1:0]      qos;
    logic [OUT_PORT_W-1:0] route;
  } sa_local_req_t;

  typedef enum logic {
    SA_IDLE = 1'b0,
    SA_HOLD = 1'b1
  } sa_state_e;

endpackage

// File: rtl/sa_rr_ptr_arb.sv
// Round-robin picker: first set bit of cand_i at or above ptr_i, searching upward with wrap-around.
module sa_rr_ptr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     cand_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr_i) + k) % N);
      if (!found && cand_i[idx]) begin
        found         = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/sa_local_qos_rr.sv
// Local switch allocator: highest effective QoS, then round-robin, grant held until read-enable.
// Optional starvation aging is enabled by defining SA_LOCAL_QOS_RR_AGING_EN.
module sa_local_qos_rr
  import noc_sa_pkg::*;
#(
  parameter int VC_NUM         = 4,
  parameter int VC_IDX_W       = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int OUT_PORT_NUM   = noc_sa_pkg::OUT_PORT_NUM,
  parameter int OUT_PORT_W     = noc_sa_pkg::OUT_PORT_W,
  parameter int QOS_W          = noc_sa_pkg::QOS_W,
  parameter int TIMEOUT_CYCLES = 10,
  parameter int AGE_THRESH     = 8,
  parameter int AGE_MAX_BOOST  = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [VC_NUM-1:0]            vc_head_vld_i,
  input  logic [VC_NUM*QOS_W-1:0]      vc_head_qos_i,
  input  logic [VC_NUM*OUT_PORT_W-1:0] vc_head_route_i,
  input  logic                         inport_read_enable_sa_stage_i,
  output logic                         sa_local_vld_o,
  output logic [VC_IDX_W-1:0]          sa_local_vc_id_o,
  output logic [VC_NUM-1:0]            sa_local_vc_id_oh_o,
  output logic [QOS_W-1:0]             sa_local_qos_value_o,
  output logic [OUT_PORT_NUM-1:0]      sa_local_vld_to_sa_global_o
);

  localparam int  CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit  TMO_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
  localparam int  BOOST_W = (AGE_MAX_BOOST > 0) ? $clog2(AGE_MAX_BOOST + 1) : 1;

  logic [QOS_W-1:0]      qos   [VC_NUM];
  logic [OUT_PORT_W-1:0] route [VC_NUM];
  logic [QOS_W-1:0]      eff   [VC_NUM];
  logic [BOOST_W-1:0]    boost [VC_NUM];
  logic [QOS_W:0]        sum;

  logic [VC_NUM-1:0]   cand, pick_oh, gnt_oh;
  logic [VC_IDX_W-1:0] pick_idx, gnt_idx, adv_ptr;
  logic [VC_IDX_W-1:0] rr_ptr_q, rr_ptr_d, hold_idx_q, hold_idx_d;
  logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  sa_state_e           state_q, state_d;
  logic                any_vld, hold_live, update, stall, timeout;

  // Effective QoS saturates instead of wrapping so a boosted VC never drops below its raw level.
  always_comb begin
    sum = '0;
    for (int i = 0; i < VC_NUM; i++) begin
      qos[i]   = vc_head_qos_i[i*QOS_W +: QOS_W];
      route[i] = vc_head_route_i[i*OUT_PORT_W +: OUT_PORT_W];
      sum      = {1'b0, qos[i]} + (QOS_W+1)'(boost[i]);
      eff[i]   = sum[QOS_W] ? {QOS_W{1'b1}} : sum[QOS_W-1:0];
    end
  end

  always_comb begin
    for (int i = 0; i < VC_NUM; i++) begin
      cand[i] = vc_head_vld_i[i];
      for (int j = 0; j < VC_NUM; j++) begin
        if (vc_head_vld_i[j] && (eff[j] > eff[i])) cand[i] = 1'b0;
      end
    end
  end

  if (VC_NUM == 1) begin : g_single
    assign pick_oh  = vc_head_vld_i;
    assign pick_idx = '0;
  end else begin : g_rr
    sa_rr_ptr_arb #(
      .N     (VC_NUM),
      .IDX_W (VC_IDX_W)
    ) u_arb (
      .cand_i    (cand),
      .ptr_i     (rr_ptr_q),
      .gnt_oh_o  (pick_oh),
      .gnt_idx_o (pick_idx)
    );
  end

  always_comb begin
    any_vld   = |vc_head_vld_i;
    hold_live = (state_q == SA_HOLD) && vc_head_vld_i[hold_idx_q];
    gnt_idx   = hold_live ? hold_idx_q : pick_idx;
    gnt_oh    = hold_live ? (VC_NUM'(1) << hold_idx_q) : pick_oh;
    update    = any_vld && inport_read_enable_sa_stage_i;
    stall     = any_vld && !inport_read_enable_sa_stage_i;
    timeout   = TMO_EN && stall && (tmo_cnt_q == TMO_LAST);
    adv_ptr   = VC_IDX_W'((int'(gnt_idx) + 1) % VC_NUM);
  end

  always_comb begin
    sa_local_vld_o       = any_vld;
    sa_local_vc_id_o     = gnt_idx;
    sa_local_vc_id_oh_o  = gnt_oh;
    sa_local_qos_value_o = any_vld ? qos[gnt_idx] : '0;
    // Out-of-range routes match no bit, leaving the global request empty.
    for (int p = 0; p < OUT_PORT_NUM; p++) begin
      sa_local_vld_to_sa_global_o[p] = any_vld && (route[gnt_idx] == OUT_PORT_W'(p));
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_idx_d = hold_idx_q;
    rr_ptr_d   = rr_ptr_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (update || timeout) begin
      rr_ptr_d  = adv_ptr;
      tmo_cnt_d = '0;
    end else if (TMO_EN && stall) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    unique case (state_q)
      SA_IDLE: if (stall && !timeout) begin
        state_d    = SA_HOLD;
        hold_idx_d = gnt_idx;
      end
      SA_HOLD: if (update || timeout || !vc_head_vld_i[hold_idx_q]) state_d = SA_IDLE;
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= SA_IDLE;
      hold_idx_q <= '0;
      rr_ptr_q   <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      hold_idx_q <= hold_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

`ifdef SA_LOCAL_QOS_RR_AGING_EN
  localparam int AGE_W = $clog2(AGE_THRESH + 1);

  logic [AGE_W-1:0]   age_q [VC_NUM];
  logic [AGE_W-1:0]   age_d [VC_NUM];
  logic [BOOST_W-1:0] boost_q [VC_NUM];
  logic [BOOST_W-1:0] boost_d [VC_NUM];

  always_comb begin
    for (int i = 0; i < VC_NUM; i++) begin
      age_d[i]   = age_q[i];
      boost_d[i] = boost_q[i];
      boost[i]   = boost_q[i];
      if (!vc_head_vld_i[i] || (update && gnt_oh[i])) begin
        age_d[i]   = '0;
        boost_d[i] = '0;
      end else if (age_q[i] == AGE_W'(AGE_THRESH - 1)) begin
        age_d[i] = '0;
        if (boost_q[i] != BOOST_W'(AGE_MAX_BOOST)) boost_d[i] = boost_q[i] + 1'b1;
      end else begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: these small per-VC arrays are flops, not RAM, and must reset so no stale boost survives.
    for (int i = 0; i < VC_NUM; i++) begin
      if (rst) begin
        age_q[i]   <= '0;
        boost_q[i] <= '0;
      end else begin
        age_q[i]   <= age_d[i];
        boost_q[i] <= boost_d[i];
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < VC_NUM; i++) boost[i] = '0;
  end
`endif

endmodule

// File: tb/tb_sa_local_qos_rr.sv
// Directed bench for sa_local_qos_rr: expected grants are queued when driven and checked on the falling edge.
module tb_sa_local_qos_rr;
  import noc_sa_pkg::*;

  localparam int VC_NUM = 4;
`ifdef SA_LOCAL_QOS_RR_AGING_EN
  localparam bit AGING = 1'b1;
`else
  localparam bit AGING = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld;
  logic [15:0] qos_bus;
  logic [11:0] route_bus;
  logic        upd;
  logic        sa_vld;
  logic [1:0]  sa_id;
  logic [3:0]  sa_oh;
  logic [3:0]  sa_qos;
  logic [5:0]  sa_glob;

  always #5 clk = ~clk;

  sa_local_qos_rr dut (
    .clk                           (clk),
    .rst                           (rst),
    .vc_head_vld_i                 (vld),
    .vc_head_qos_i                 (qos_bus),
    .vc_head_route_i               (route_bus),
    .inport_read_enable_sa_stage_i (upd),
    .sa_local_vld_o                (sa_vld),
    .sa_local_vc_id_o              (sa_id),
    .sa_local_vc_id_oh_o           (sa_oh),
    .sa_local_qos_value_o          (sa_qos),
    .sa_local_vld_to_sa_global_o   (sa_glob)
  );

  typedef struct {
    string      tag;
    logic       vld;
    logic [1:0] id;
    logic [3:0] qos;
    logic [5:0] glob;
  } exp_t;

  sa_local_req_t req [VC_NUM];
  exp_t          sb [$];
  int            n_checks = 0;
  int            n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_vc(input int i, input logic v, input logic [3:0] q, input logic [2:0] r);
    req[i] = '{vld: v, qos: q, route: r};
  endtask

  task automatic set_vld(input logic [3:0] m);
    for (int i = 0; i < VC_NUM; i++) req[i].vld = m[i];
  endtask

  task automatic apply();
    for (int i = 0; i < VC_NUM; i++) begin
      vld[i]             = req[i].vld;
      qos_bus[i*4 +: 4]  = req[i].qos;
      route_bus[i*3 +: 3] = req[i].route;
    end
  endtask

  task automatic compare();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_errs++;
      $error("FAIL scoreboard_empty: observed=no entry expected=one entry");
    end else begin
      e = sb.pop_front();
      check({e.tag, ".vld"},  32'(sa_vld),  32'(e.vld));
      check({e.tag, ".id"},   32'(sa_id),   32'(e.id));
      check({e.tag, ".oh"},   32'(sa_oh),   e.vld ? (32'(1) << e.id) : 32'(0));
      check({e.tag, ".qos"},  32'(sa_qos),  32'(e.qos));
      check({e.tag, ".glob"}, 32'(sa_glob), 32'(e.glob));
    end
  endtask

  // Drive the current request table, queue the expected grant, compare before the next edge.
  task automatic step(input string tag, input logic u, input logic e_vld, input int e_id);
    exp_t e;
    apply();
    upd    = u;
    e.tag  = tag;
    e.vld  = e_vld;
    e.id   = 2'(e_id);
    e.qos  = e_vld ? req[e_id].qos : 4'h0;
    e.glob = (e_vld && (req[e_id].route < 3'd6)) ? (6'(1) << req[e_id].route) : 6'h0;
    sb.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < VC_NUM; i++) set_vc(i, 1'b0, 4'd0, 3'd0);
    apply();
    upd = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, and an update with nothing valid is ignored.
    step("rst_idle", 1'b0, 1'b0, 0);
    step("rst_idle_upd", 1'b1, 1'b0, 0);

    // Equal QoS, served every cycle: plain rotation from pointer 0.
    for (int i = 0; i < VC_NUM; i++) set_vc(i, 1'b1, 4'd2, 3'(i));
    for (int k = 0; k < 5; k++) step("rr_rotate", 1'b1, 1'b1, k % 4);

    // Highest QoS wins regardless of pointer; route decode incl. edge and out-of-range.
    set_vc(0, 1'b1, 4'd1, 3'd0);
    set_vc(1, 1'b0, 4'd0, 3'd0);
    set_vc(2, 1'b1, 4'd5, 3'd4);
    set_vc(3, 1'b0, 4'd0, 3'd0);
    step("qos_pick", 1'b1, 1'b1, 2);
    set_vc(2, 1'b1, 4'd5, 3'd7);
    step("route_oob", 1'b1, 1'b1, 2);
    set_vc(2, 1'b1, 4'd5, 3'd5);
    step("route_max", 1'b1, 1'b1, 2);

    // Hold: grant stays on VC1 while VC3 outranks it, then falls back the cycle VC1 drops.
    set_vc(0, 1'b0, 4'd0, 3'd0);
    set_vc(1, 1'b1, 4'd6, 3'd1);
    set_vc(2, 1'b0, 4'd0, 3'd0);
    set_vc(3, 1'b1, 4'd2, 3'd3);
    step("hold_enter", 1'b0, 1'b1, 1);
    set_vc(3, 1'b1, 4'd15, 3'd3);
    step("hold_keep", 1'b0, 1'b1, 1);
    step("hold_keep", 1'b0, 1'b1, 1);
    set_vld(4'b1000);
    step("hold_drop", 1'b0, 1'b1, 3);
    step("hold_serve", 1'b1, 1'b1, 3);

    // Timeout after 10 stalled cycles, counter restarts, then update on the expiry cycle.
    for (int i = 0; i < VC_NUM; i++) set_vc(i, 1'b0, 4'd2, 3'(i));
    set_vld(4'b0011);
    for (int k = 0; k < 10; k++) step("tmo_first", 1'b0, 1'b1, 0);
    for (int k = 0; k < 10; k++) step("tmo_second", 1'b0, 1'b1, 1);
    for (int k = 0; k < 9; k++) step("tmo_third", 1'b0, 1'b1, 0);
    step("tmo_upd_same", 1'b1, 1'b1, 0);
    set_vld(4'b0000);
    step("gap", 1'b0, 1'b0, 0);
    set_vld(4'b1111);
    step("single_adv", 1'b1, 1'b1, 1);
    set_vld(4'b0000);
    step("gap", 1'b0, 1'b0, 0);

    // Aging: VC1 (qos 3) catches up with always-served VC0 (qos 4) only in the aging build.
    for (int i = 0; i < VC_NUM; i++) set_vc(i, 1'b0, 4'd0, 3'(i));
    set_vc(0, 1'b1, 4'd4, 3'd0);
    set_vc(1, 1'b1, 4'd3, 3'd1);
    for (int k = 0; k < 10; k++) step("aging", 1'b1, 1'b1, (AGING && k == 8) ? 1 : 0);

    // Reset in the middle of a hold on VC1: no grant is carried over, pointer back to 0.
    set_vc(0, 1'b1, 4'd2, 3'd0);
    set_vc(1, 1'b1, 4'd2, 3'd1);
    step("pre_rst_hold", 1'b0, 1'b1, 1);
    step("pre_rst_hold", 1'b0, 1'b1, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst", 1'b0, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
